csa_sub_48bit_seq: RTL
======================

Name: csa_sub_48bit_seq

Overview:
- Sequential 48-bit carry-select subtractor: computes i_minuend - i_subtrahend in the inverse direction of the carry-select adder datapath.
- Processes one CHUNK-bit slice per clock, built from 4-bit carry-select slices. Trades latency for a short critical path.
- Sits behind a valid/ready producer and drives a valid/ready consumer. Holds one transaction at a time.

Parameters:
- WIDTH, 48, operand/result width; must be a multiple of CHUNK.
- CHUNK, 12, bits resolved per clock; must be a multiple of 4.
- NCHUNK, WIDTH/CHUNK (localparam, 4), cycles per subtraction.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  operands present on i_minuend/i_subtrahend.
- o_ready  output  1  block can accept operands.
- i_minuend  input  WIDTH  A.
- i_subtrahend  input  WIDTH  B.
- o_valid  output  1  result present.
- i_ready  input  1  consumer accepts result.
- o_diff  output  WIDTH  (A - B) mod 2^WIDTH.
- o_borrow  output  1  1 when A < B unsigned.
- o_zero  output  1  1 when o_diff == 0.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, o_ready=1, o_valid=0, o_diff=0, o_borrow=0, o_zero=0.
  - Internal operand regs, chunk counter and carry cleared.
- States:
  - IDLE -> BUSY on accept (i_valid & o_ready). Latch A and ~B, carry=1 (two's-complement increment), cnt=0.
  - BUSY: each edge computes chunk cnt. A[cnt*CHUNK +: CHUNK] + ~B[...] + carry goes through CHUNK/4 carry-select slices; the first slice uses the incoming carry directly.
    - The result is written to o_diff[cnt*CHUNK +: CHUNK]; carry <= chunk carry-out; cnt++.
    - Edge with cnt==NCHUNK-1: -> DONE, o_borrow <= ~final carry, o_zero <= (full diff == 0).
  - DONE: o_valid=1, outputs stable. On i_ready -> IDLE, o_valid=0.
- Handshake:
  - o_ready=1 only in IDLE. No overlap of transactions.
  - o_valid=1 only in DONE; held, with o_diff/o_borrow/o_zero constant, until i_ready.
  - i_valid may stay high across transactions; the next accept occurs only after the return to IDLE, so at most one result per NCHUNK+2 cycles under continuous traffic.
- Latency: accept edge at cycle 0 -> o_valid high after edge NCHUNK (4 edges of BUSY). Zero-stall throughput = one op per NCHUNK+2 cycles.
- o_diff is partially updated during BUSY. Consumers must sample only when o_valid=1.
- i_minuend/i_subtrahend are don't-care after the accept edge, because they are latched.
- i_ready while not in DONE: ignored.
- Reset asserted mid-BUSY or mid-DONE: immediate return to reset values. The in-flight result is discarded and no o_valid is produced.
- Arithmetic: unsigned modular. o_borrow = ~carry_out. Signed overflow is not reported.
- CHUNK==WIDTH is legal: single-cycle BUSY.
- Illegal parameters trigger an elaboration-time error: WIDTH % CHUNK != 0, or CHUNK % 4 != 0.

Decomposition:
- Shared package csa_pkg:
  - state encoding typedef (IDLE, BUSY, DONE);
  - SLICE_W=4 constant;
  - parameter-legality check function.
- Sub-module csa_sub_slice4, combinational: 4-bit A, 4-bit ~B, cin -> 4-bit sum, cout. It computes both carry-in cases and selects on cin.
- Top-level generate instantiates CHUNK/4 slices in a chain for the active chunk. The chunk is selected by a cnt-indexed mux on the latched operands.

Test Plan:
- Reset then accept A=48'h0000_0000_0005, B=48'h0000_0000_0003 -> o_valid exactly 4 cycles after the accept edge; o_diff=48'h2, o_borrow=0, o_zero=0.
- A=0, B=1 -> o_diff=48'hFFFF_FFFF_FFFF, o_borrow=1, o_zero=0. This checks the borrow across all chunks.
- A=48'h0010_0000_0000, B=1 -> o_diff=48'h000F_FFFF_FFFF, o_borrow=0. This checks borrow propagation through 3 chunk boundaries.
- A=B=48'hA5A5_5A5A_F00F -> o_diff=0, o_zero=1, o_borrow=0.
- Hold i_ready=0 for 10 cycles in DONE while i_valid=1 with new operands -> o_valid, o_diff and o_borrow are stable and o_ready=0. After i_ready, the next operands are accepted 1 cycle later.
- Deassert i_rst_n at BUSY cnt=2 -> all outputs reach reset values asynchronously. After release, o_valid never rises for the aborted op, and a fresh op A=7, B=9 yields o_diff=48'hFFFF_FFFF_FFFE, o_borrow=1.

Source files
------------

// File: rtl/csa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : csa_pkg                                                         |
// | Brief    : Shared types and constants for the sequential CSA subtractor.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package csa_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when the operand width splits into whole chunks of whole 4-bit slices.
    function automatic bit params_legal(input int width, input int chunk);
        return (chunk > 0) && (width > 0) && (chunk % SLICE_W == 0) && (width % chunk == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_sub_slice4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : csa_sub_slice4                                                  |
// | Brief    : 4-bit carry-select slice; both carry-in sums precomputed.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module csa_sub_slice4 (
    input  logic [3:0] a_i,
    input  logic [3:0] nb_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [4:0] w_sum_c0;
    logic [4:0] w_sum_c1;

    assign w_sum_c0 = {1'b0, a_i} + {1'b0, nb_i};
    assign w_sum_c1 = {1'b0, a_i} + {1'b0, nb_i} + 5'd1;

    assign {cout_o, sum_o} = cin_i ? w_sum_c1 : w_sum_c0;

endmodule
`default_nettype wire

// File: rtl/csa_sub_48bit_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : csa_sub_48bit_seq                                               |
// | Brief    : Chunk-serial carry-select subtractor with valid/ready handshake.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module csa_sub_48bit_seq
    import csa_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int CHUNK = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int NSLICE = CHUNK / SLICE_W;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(NCHUNK - 1);

    generate
        if (!params_legal(WIDTH, CHUNK)) begin : g_param_check
            $error("csa_sub_48bit_seq: WIDTH must be a multiple of CHUNK and CHUNK a multiple of 4");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   nb_q, nb_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               borrow_q, borrow_d;
    logic               zero_q, zero_d;

    logic               w_accept;
    logic               w_last;
    logic [CHUNK-1:0]   w_a_chunks  [NCHUNK];
    logic [CHUNK-1:0]   w_nb_chunks [NCHUNK];
    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_nb_chunk;
    logic [CHUNK-1:0]   w_chunk_sum;
    logic [NSLICE:0]    w_carry;

    // Operand chunk selection: an array view of the latched operands indexed by cnt.
    generate
        for (genvar k = 0; k < NCHUNK; k++) begin : g_chunk
            assign w_a_chunks[k]  = a_q[k*CHUNK +: CHUNK];
            assign w_nb_chunks[k] = nb_q[k*CHUNK +: CHUNK];
        end
    endgenerate

    assign w_a_chunk  = w_a_chunks[cnt_q];
    assign w_nb_chunk = w_nb_chunks[cnt_q];
    assign w_carry[0] = carry_q;

    generate
        for (genvar s = 0; s < NSLICE; s++) begin : g_slice
            csa_sub_slice4 u_slice (
                .a_i    (w_a_chunk[s*SLICE_W +: SLICE_W]),
                .nb_i   (w_nb_chunk[s*SLICE_W +: SLICE_W]),
                .cin_i  (w_carry[s]),
                .sum_o  (w_chunk_sum[s*SLICE_W +: SLICE_W]),
                .cout_o (w_carry[s+1])
            );
        end
    endgenerate

    assign w_accept = i_valid && (state_q == ST_IDLE);
    assign w_last   = (state_q == ST_BUSY) && (cnt_q == c_cnt_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_valid) state_d = ST_BUSY;
            ST_BUSY: if (w_last)  state_d = ST_DONE;
            ST_DONE: if (i_ready) state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ready  = (state_q == ST_IDLE);
        o_valid  = (state_q == ST_DONE);
        o_diff   = diff_q;
        o_borrow = borrow_q;
        o_zero   = zero_q;
    end

    // Subtrahend is stored inverted; carry seeded to 1 completes the two's complement.
    always_comb begin
        a_d      = a_q;
        nb_d     = nb_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        if (w_accept) begin
            a_d     = i_minuend;
            nb_d    = ~i_subtrahend;
            carry_d = 1'b1;
            cnt_d   = '0;
        end else if (state_q == ST_BUSY) begin
            for (int k = 0; k < NCHUNK; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    diff_d[k*CHUNK +: CHUNK] = w_chunk_sum;
                end
            end
            carry_d = w_carry[NSLICE];
            cnt_d   = cnt_q + CNT_W'(1);
            if (w_last) begin
                cnt_d    = '0;
                borrow_d = ~w_carry[NSLICE];
                zero_d   = (diff_d == '0);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q      <= '0;
            nb_q     <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            nb_q     <= nb_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

endmodule
`default_nettype wire
